// File: rtl/mips_tb_pkg.sv
// Shared definitions for the MIPS run checker: verdict FSM encoding and
// default run parameters for the reference test program.
package mips_tb_pkg;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_PASS = 2'd1,
    ST_FAIL = 2'd2,
    ST_TOUT = 2'd3
  } run_state_t;

  localparam logic [31:0] DEF_HALT_PC   = 32'h58;
  localparam logic [31:0] DEF_EXP_ADR   = 32'd84;
  localparam logic [31:0] DEF_EXP_DATA  = 32'd7;
  localparam logic [31:0] DEF_OK_ADR    = 32'd80;
  localparam logic [31:0] DEF_TIMEOUT   = 32'd1000;
  localparam int          DEF_LOG_DEPTH = 8;

  // One store-log entry is {address, data}.
  localparam int LOG_ENTRY_W = 64;

endpackage

// File: rtl/store_log_fifo.sv
// Store-log FIFO: circular buffer with a valid/ready pop port, a drop-on-full
// push port and a sticky overflow flag. DEPTH must be a power of two >= 2 so
// the pointers wrap naturally.
module store_log_fifo #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_push,
  input  logic [DATA_W-1:0] i_push_data,
  input  logic              i_pop_ready,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_head,
  output logic              o_overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wptr;
  logic [AW-1:0]     r_rptr;
  logic [CW-1:0]     r_count;
  logic              r_overflow;

  logic w_empty;
  logic w_full;
  logic w_pop;
  logic w_push_ok;
  logic w_drop;

  // Pop only when an entry exists; a push into a full log survives only if a
  // pop frees a slot on the same edge. Push into an empty log is never popped
  // in that cycle because valid is still low.
  always_comb begin
    w_empty   = (r_count == '0);
    w_full    = (r_count == FULL_CNT);
    w_pop     = !w_empty && i_pop_ready;
    w_push_ok = i_push && (!w_full || w_pop);
    w_drop    = i_push && w_full && !w_pop;
  end

  // Entry storage; data carries no reset, emptiness is tracked by the count.
  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_mem[r_wptr] <= i_push_data;
    end
  end

  // Pointers, occupancy and the sticky overflow flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push_ok) begin
        r_wptr <= r_wptr + AW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + AW'(1);
      end
      case ({w_push_ok, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  // Head is forced to zero while empty so stale slots never leak out.
  always_comb begin
    o_valid    = !w_empty;
    o_head     = w_empty ? '0 : r_mem[r_rptr];
    o_overflow = r_overflow;
  end

endmodule

// File: rtl/mips_run_checker.sv
// Run checker for a MIPS test program: watches PC and data stores, decides
// PASS / FAIL / TIMEOUT, counts cycles and stores, and logs every store seen
// while the run is live.
module mips_run_checker
  import mips_tb_pkg::*;
#(
  parameter logic [31:0] HALT_PC   = DEF_HALT_PC,
  parameter logic [31:0] EXP_ADR   = DEF_EXP_ADR,
  parameter logic [31:0] EXP_DATA  = DEF_EXP_DATA,
  parameter logic [31:0] OK_ADR    = DEF_OK_ADR,
  parameter logic [31:0] TIMEOUT   = DEF_TIMEOUT,
  parameter int          LOG_DEPTH = DEF_LOG_DEPTH
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc,
  input  logic        memwrite,
  input  logic [31:0] dataadr,
  input  logic [31:0] writedata,
  output logic        done,
  output logic        pass,
  output logic        fail,
  output logic        timeout,
  output logic [31:0] cycle_count,
  output logic [15:0] store_count,
  output logic        log_valid,
  input  logic        log_ready,
  output logic [31:0] log_adr,
  output logic [31:0] log_data,
  output logic        log_overflow
);

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  run_state_t r_state;
  run_state_t w_next;
  logic [31:0] r_cycle_count;
  logic [15:0] r_store_count;

  logic w_running;
  logic w_store_good;
  logic w_store_bad;
  logic w_halt;
  logic w_tout;
  logic w_log_push;
  logic [LOG_ENTRY_W-1:0] w_log_head;

  // Event decode for the current RUN cycle.
  always_comb begin
    w_running    = (r_state == ST_RUN);
    w_store_good = memwrite && (dataadr == EXP_ADR) && (writedata == EXP_DATA);
    w_store_bad  = memwrite &&
                   (((dataadr == EXP_ADR) && (writedata != EXP_DATA)) ||
                    ((dataadr != EXP_ADR) && (dataadr != OK_ADR)));
    w_halt       = (pc == HALT_PC);
    w_tout       = (r_cycle_count == TIMEOUT - 32'd1);
    w_log_push   = w_running && memwrite;
  end

  // Next-state: FAIL beats PASS beats TOUT; verdict states are terminal.
  always_comb begin
    w_next = r_state;
    if (w_running) begin
      if (w_store_bad) begin
        w_next = ST_FAIL;
      end else if (w_store_good || w_halt) begin
        w_next = ST_PASS;
      end else if (w_tout) begin
        w_next = ST_TOUT;
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_next;
    end
  end

  // Run counters; they only advance in RUN, so they freeze on any verdict.
  // The triggering store is counted because it is still sampled in RUN.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cycle_count <= '0;
      r_store_count <= '0;
    end else if (w_running) begin
      r_cycle_count <= r_cycle_count + 32'd1;
      if (memwrite) begin
        r_store_count <= sat_inc16(r_store_count);
      end
    end
  end

  store_log_fifo #(
    .DATA_W (LOG_ENTRY_W),
    .DEPTH  (LOG_DEPTH)
  ) u_log (
    .clk         (clk),
    .reset       (reset),
    .i_push      (w_log_push),
    .i_push_data ({dataadr, writedata}),
    .i_pop_ready (log_ready),
    .o_valid     (log_valid),
    .o_head      (w_log_head),
    .o_overflow  (log_overflow)
  );

  // Verdicts decode straight from the state register, so they are registered.
  always_comb begin
    pass        = (r_state == ST_PASS);
    fail        = (r_state == ST_FAIL);
    timeout     = (r_state == ST_TOUT);
    done        = pass | fail | timeout;
    cycle_count = r_cycle_count;
    store_count = r_store_count;
    log_adr     = w_log_head[63:32];
    log_data    = w_log_head[31:0];
  end

endmodule

// File: tb/tb_mips_run_checker.sv
module tb_mips_run_checker;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc;
  logic        memwrite;
  logic [31:0] dataadr;
  logic [31:0] writedata;
  logic        done, pass, fail, timeout;
  logic [31:0] cycle_count;
  logic [15:0] store_count;
  logic        log_valid;
  logic        log_ready;
  logic [31:0] log_adr, log_data;
  logic        log_overflow;

  int n_vec = 0;
  int n_miss = 0;

  mips_run_checker #(
    .HALT_PC   (32'h58),
    .EXP_ADR   (32'd84),
    .EXP_DATA  (32'd7),
    .OK_ADR    (32'd80),
    .TIMEOUT   (32'd20),
    .LOG_DEPTH (8)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .pc           (pc),
    .memwrite     (memwrite),
    .dataadr      (dataadr),
    .writedata    (writedata),
    .done         (done),
    .pass         (pass),
    .fail         (fail),
    .timeout      (timeout),
    .cycle_count  (cycle_count),
    .store_count  (store_count),
    .log_valid    (log_valid),
    .log_ready    (log_ready),
    .log_adr      (log_adr),
    .log_data     (log_data),
    .log_overflow (log_overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    memwrite  = 1'b0;
    dataadr   = 32'd0;
    writedata = 32'd0;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    memwrite  = 1'b1;
    dataadr   = a;
    writedata = d;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle();
    pc        = 32'd0;
    log_ready = 1'b0;
    cyc();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    pc = 32'd0;
    log_ready = 1'b0;
    idle();

    // Reset state
    repeat (3) cyc();
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_fail", fail, 0);
    chk("rst_tout", timeout, 0);
    chk("rst_lvalid", log_valid, 0);
    chk("rst_ovf", log_overflow, 0);
    chk("rst_ladr", log_adr, 0);
    chk("rst_ldata", log_data, 0);
    chk("rst_scnt", store_count, 0);
    reset = 1'b0;
    chk("first_ccnt", cycle_count, 0);

    // Good store sequence ends in PASS
    store(32'd80, 32'd5);
    cyc();
    chk("a_ccnt1", cycle_count, 1);
    chk("a_pass_early", pass, 0);
    chk("a_ladr0", log_adr, 80);
    store(32'd84, 32'd7);
    cyc();
    chk("a_pass", pass, 1);
    chk("a_done", done, 1);
    chk("a_scnt", store_count, 2);
    idle();
    store(32'd96, 32'd1);
    cyc();
    chk("a_frozen_ccnt", cycle_count, 2);
    chk("a_frozen_scnt", store_count, 2);
    chk("a_still_pass", pass, 1);
    idle();
    log_ready = 1'b1;
    chk("a_pop0_adr", log_adr, 80);
    chk("a_pop0_data", log_data, 5);
    cyc();
    chk("a_pop1_adr", log_adr, 84);
    chk("a_pop1_data", log_data, 7);
    cyc();
    chk("a_empty", log_valid, 0);
    chk("a_empty_adr", log_adr, 0);

    // Bad address -> FAIL, still logged
    do_reset();
    store(32'd96, 32'd1);
    cyc();
    chk("b_fail", fail, 1);
    chk("b_pass", pass, 0);
    chk("b_scnt", store_count, 1);
    chk("b_lvalid", log_valid, 1);
    chk("b_ladr", log_adr, 96);

    // Expected store together with halt PC -> PASS
    do_reset();
    pc = 32'h58;
    store(32'd84, 32'd7);
    cyc();
    chk("c_pass", pass, 1);
    chk("c_fail", fail, 0);

    // Wrong data at expected address wins over halt PC -> FAIL
    do_reset();
    pc = 32'h58;
    store(32'd84, 32'd3);
    cyc();
    chk("d_fail", fail, 1);
    chk("d_pass", pass, 0);

    // Halt PC alone -> PASS
    do_reset();
    pc = 32'h58;
    cyc();
    chk("e_pass", pass, 1);
    chk("e_scnt", store_count, 0);

    // Timeout after 20 RUN cycles, then frozen
    do_reset();
    repeat (19) cyc();
    chk("f_tout_early", timeout, 0);
    chk("f_ccnt19", cycle_count, 19);
    cyc();
    chk("f_tout", timeout, 1);
    chk("f_done", done, 1);
    chk("f_ccnt", cycle_count, 20);
    store(32'd80, 32'd9);
    repeat (3) cyc();
    chk("f_frozen", cycle_count, 20);
    chk("f_no_log", log_valid, 0);
    chk("f_no_scnt", store_count, 0);

    // Nine stores into an 8-deep log with no consumer -> overflow
    do_reset();
    for (int i = 0; i < 8; i++) begin
      store(32'd80, i);
      cyc();
    end
    chk("g_ovf_early", log_overflow, 0);
    store(32'd80, 32'd8);
    cyc();
    chk("g_ovf", log_overflow, 1);
    chk("g_scnt", store_count, 9);
    chk("g_fail", fail, 0);
    idle();
    log_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("g_pop_data", log_data, i);
      cyc();
    end
    chk("g_drained", log_valid, 0);
    chk("g_ovf_sticky", log_overflow, 1);

    // Full log with simultaneous push and pop -> no overflow, occupancy kept
    do_reset();
    for (int i = 0; i < 8; i++) begin
      store(32'd80, i);
      cyc();
    end
    store(32'd80, 32'd8);
    log_ready = 1'b1;
    cyc();
    chk("h_ovf", log_overflow, 0);
    chk("h_head", log_data, 1);
    idle();
    for (int i = 1; i < 9; i++) begin
      chk("h_pop_data", log_data, i);
      cyc();
    end
    chk("h_drained", log_valid, 0);

    // Push with ready high into an empty log -> entry stays for one cycle
    do_reset();
    log_ready = 1'b1;
    store(32'd80, 32'd5);
    cyc();
    chk("i_valid", log_valid, 1);
    chk("i_data", log_data, 5);
    idle();
    cyc();
    chk("i_popped", log_valid, 0);

    // Reset mid-run discards log contents
    do_reset();
    for (int i = 0; i < 3; i++) begin
      store(32'd80, i + 10);
      cyc();
    end
    idle();
    chk("j_valid_pre", log_valid, 1);
    reset = 1'b1;
    cyc();
    chk("j_valid", log_valid, 0);
    chk("j_ccnt", cycle_count, 0);
    chk("j_scnt", store_count, 0);
    reset = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/mips_run_checker.md
MIPS_RUN_CHECKER -- requirements
Module: mips_run_checker

Interface
REQ-001 Parameter HALT_PC, 32'h58, PC value that ends the run successfully.
REQ-002 Parameter EXP_ADR, 32'd84, store address of the expected result store.
REQ-003 Parameter EXP_DATA, 32'd7, store data of the expected result store.
REQ-004 Parameter OK_ADR, 32'd80, the only other address a store may target.
REQ-005 Parameter TIMEOUT, 32'd1000, maximum RUN cycles before the run is declared hung.
REQ-006 Parameter LOG_DEPTH, 8, store-log FIFO depth; must be a power of two and at least 2.
REQ-007 Port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-008 Port reset, input, 1, synchronous active-high reset.
REQ-009 Port pc, input, 32, current CPU program counter.
REQ-010 Port memwrite, input, 1, CPU data-memory write strobe.
REQ-011 Port dataadr, input, 32, CPU data address.
REQ-012 Port writedata, input, 32, CPU store data.
REQ-013 Port done, output, 1, run has ended (PASS, FAIL or TOUT).
REQ-014 Port pass / fail / timeout, outputs, 1 each, one-hot verdict; all 0 while running.
REQ-015 Port cycle_count, output, 32, number of RUN cycles elapsed.
REQ-016 Port store_count, output, 16, number of stores seen in RUN; saturates at 16'hFFFF.
REQ-017 Port log_valid, output, 1, store-log FIFO is non-empty.
REQ-018 Port log_ready, input, 1, consumer pops the head entry when log_valid is 1.
REQ-019 Port log_adr / log_data, outputs, 32 each, head entry of the log; 0 when empty.
REQ-020 Port log_overflow, output, 1, sticky flag: a store was dropped because the log was full.

Function
REQ-021 FSM states: RUN, PASS, FAIL, TOUT; the first cycle after reset deasserts is in RUN.
REQ-022 In RUN, cycle_count increments by 1 every cycle.
REQ-023 In RUN with memwrite=1, dataadr==EXP_ADR and writedata==EXP_DATA: next state PASS.
REQ-024 In RUN with memwrite=1 and dataadr not EXP_ADR and not OK_ADR: next state FAIL.
REQ-025 In RUN with memwrite=1 and dataadr==EXP_ADR but writedata!=EXP_DATA: next state FAIL.
REQ-026 In RUN with pc==HALT_PC and no FAIL condition in the same cycle: next state PASS.
REQ-027 Priority when several conditions hold in one cycle: FAIL, then PASS, then TOUT.
REQ-028 In RUN with cycle_count==TIMEOUT-1 and no other event: next state TOUT.
REQ-029 PASS, FAIL and TOUT are terminal until reset; counters freeze; no further log pushes.
REQ-030 Verdict outputs are registered; they assert the cycle after the triggering edge, and done = pass | fail | timeout.
REQ-031 In RUN, each memwrite=1 cycle increments store_count and pushes {dataadr, writedata} into the log.
REQ-032 The store that causes the PASS or FAIL transition is still counted and logged.
REQ-033 A pop occurs on any cycle with log_valid & log_ready; a pop is legal in every state.
REQ-034 Push to a full log with no pop in the same cycle is dropped, and log_overflow is set.
REQ-035 Push and pop in the same cycle when full: both occur; occupancy is unchanged; no overflow.
REQ-036 Push and pop in the same cycle when empty: push only; log_valid=1 on the next cycle.
REQ-037 Log pointers wrap modulo LOG_DEPTH; occupancy is tracked with a count of width log2(LOG_DEPTH)+1.

Reset
REQ-038 While reset=1 the state is RUN and cycle_count, store_count, and the log pointers and count are 0.
REQ-039 While reset=1 done, pass, fail, timeout, log_valid and log_overflow are 0, and log_adr and log_data are 0.
REQ-040 A reset asserted mid-run or in a terminal state takes effect at the next edge and discards all log contents.

Structure
REQ-041 State encoding and default parameter values live in the shared package mips_tb_pkg.
REQ-042 The store log is a sub-module store_log_fifo (parameterised width and depth, valid/ready pop).

Verification
REQ-043 Reset 3 cycles -> all outputs 0; first post-reset cycle has cycle_count=0.
REQ-044 Store (80,5) then (84,7) -> pass=1 one cycle later; store_count=2; log pops (80,5) then (84,7).
REQ-045 Store (96,1) -> fail=1; in the same cycle as (84,7) with pc=0x58 -> PASS; (84,3) -> FAIL.
REQ-046 No stores and pc never 0x58, TIMEOUT=20 -> timeout=1 with cycle_count=20; frozen afterwards.
REQ-047 9 stores to 80 with log_ready=0 and LOG_DEPTH=8 -> overflow=1, 8 entries; a full push+pop cycle leaves overflow clear.
REQ-048 Reset asserted mid-run with 3 entries in the log -> log_valid=0 and cycle_count=0 the next cycle.
